// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   MUL_WIDTH   : default operand width (product is 2*MUL_WIDTH bits)
//   mul_state_t : controller states IDLE -> RUN -> DONE -> IDLE
//   booth_op_t  : per-step accumulator operation chosen by {Q[0],Q_-1}
//   booth_decode: maps the examined bit pair to a booth_op_t
package mul_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // {Q[0], Q_-1}: 10 starts a run of ones (subtract), 01 ends one (add).
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b10:   op = BOOTH_SUB;
      2'b01:   op = BOOTH_ADD;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a_i   [WIDTH:0]   accumulator A (one guard bit so the most-negative M is exact)
//   q_i   [WIDTH-1:0] multiplier / low product half Q
//   qm1_i             Q_-1 bit
//   m_i   [WIDTH:0]   sign-extended multiplicand M
//   a_o, q_o, qm1_o   next {A,Q,Q_-1} after add/sub and arithmetic right shift
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case (booth_decode({q_i[0], qm1_i}))
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
  end

  // Arithmetic shift of {A,Q,Q_-1}: A's sign bit is replicated.
  assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle signed WIDTH x WIDTH -> 2*WIDTH radix-2 Booth multiplier.
// Optional build macro: MUL_ZERO_BYPASS_EN (zero operand finishes in 2 cycles).
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request, sampled only in IDLE
//   mul1       signed multiplicand, captured on acceptance
//   mul2       signed multiplier, captured on acceptance
//   mulresult  signed product, updated only when leaving DONE (or cleared by reset)
//   busy       high in RUN and DONE
//   done       one-cycle pulse: mulresult is new
// Handshake: start is a request strobe acted on only when busy=0; while busy=1
// it is ignored and not queued. done pulses once per accepted request, in the
// cycle after DONE, and a new start can be accepted in that same cycle.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic [2*WIDTH-1:0]   mulresult,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [2*WIDTH-1:0]   mulresult_q, mulresult_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       a_nx;
  logic [WIDTH-1:0]     q_nx;
  logic                 qm1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_nx),
    .q_o   (q_nx),
    .qm1_o (qm1_nx)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    m_d         = m_q;
    mulresult_d = mulresult_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          qm1_d   = 1'b0;
          m_d     = {mul1[WIDTH-1], mul1};
          q_d     = mul2;
          count_d = CW'(WIDTH);
          state_d = RUN;
`ifdef MUL_ZERO_BYPASS_EN
          // Zero Q and M so {A,Q} already reads as the zero product.
          if ((mul1 == '0) || (mul2 == '0)) begin
            q_d     = '0;
            m_d     = '0;
            count_d = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        a_d     = a_nx;
        q_d     = q_nx;
        qm1_d   = qm1_nx;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        // A's guard bit equals A[WIDTH-1] for any in-range product.
        mulresult_d = {a_q[WIDTH-1:0], q_q};
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      a_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      m_q         <= '0;
      mulresult_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      m_q         <= m_d;
      mulresult_q <= mulresult_d;
      done_q      <= done_d;
    end
  end

  assign mulresult = mulresult_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W = 16;
  localparam int FULL_LAT = W + 1;
`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    mul1;
  logic [W-1:0]    mul2;
  logic [2*W-1:0]  mulresult;
  logic            busy;
  logic            done;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;

  seq_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mul1      (mul1),
    .mul2      (mul2),
    .mulresult (mulresult),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got mulresult=%h with no request outstanding", mulresult);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (mulresult !== e) begin
          n_err++;
          $display("FAIL product: got %h expected %h", mulresult, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int exp_lat, input bit hold);
    int lat;
    int busy_cnt;
    bit seen;
    int hold_bad;
    lat = 0; busy_cnt = 0; seen = 0; hold_bad = 0;
    start = 1'b1; mul1 = a; mul2 = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = hold;
    mul1 = W'($urandom_range(0, 65535));
    mul2 = W'($urandom_range(0, 65535));
    while (lat < 40) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin seen = 1; break; end
      if (mulresult !== last_res) hold_bad++;
      @(posedge clk);
      #1;
      if (hold) begin
        mul1 = W'($urandom_range(0, 65535));
        mul2 = W'($urandom_range(0, 65535));
      end
      lat++;
    end
    start = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL timeout: no done for %h*%h after %0d cycles", a, b, lat);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
      check("hold_during_run", 32'(hold_bad), 32'd0);
    end
    last_res = exp;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    int sa, sb;
    logic [2*W-1:0] rexp;

    rst_n = 1'b0; start = 1'b0; mul1 = '0; mul2 = '0; last_res = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mulresult", mulresult, '0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    // directed vectors
    do_mul(16'd3,      16'd5,      32'h0000000F, FULL_LAT, 0); idle(2);
    do_mul(16'h8000,   16'h8000,   32'h40000000, FULL_LAT, 0); idle(2);
    do_mul(16'h8000,   16'd1,      32'hFFFF8000, FULL_LAT, 0); idle(2);
    do_mul(16'hFFFF,   16'd1,      32'hFFFFFFFF, FULL_LAT, 0); idle(2);
    do_mul(16'd7,      16'hFFFD,   32'hFFFFFFEB, FULL_LAT, 0); idle(2);

    // start held high while busy, then back-to-back acceptance right after done
    do_mul(16'd100,    16'd200,    32'h00004E20, FULL_LAT, 1);
    do_mul(16'hFFF6,   16'd10,     32'hFFFFFF9C, FULL_LAT, 0);
    idle(3);

    // reset during RUN aborts without a done
    start = 1'b1; mul1 = 16'd1000; mul2 = 16'd1000;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_mulresult", mulresult, '0);
    last_res = '0;
    do_mul(16'd2,      16'd3,      32'h00000006, FULL_LAT, 0); idle(2);

    // zero operands
    do_mul(16'd0,      16'd1234,   32'h00000000, ZERO_LAT, 0); idle(2);
    do_mul(16'hABCD,   16'd0,      32'h00000000, ZERO_LAT, 0); idle(2);

    // random signed pairs against a reference product
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(1, 65535));
      rb = W'($urandom_range(1, 65535));
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      rexp = 32'(sa * sb);
      do_mul(ra, rb, rexp, FULL_LAT, 0);
      idle(1);
    end

    idle(30);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL outstanding: %0d results never returned, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
